bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Parametrised N-digit decimal up/down counter with a built-in tick prescaler. It counts directly in packed BCD, so no separate hex-to-BCD conversion stage is needed. It sits between the board clock and the TM1638 display driver, and its digit outputs feed the driver's 4-bit digit inputs directly. It replaces the fixed 8-bit binary counter with load, clear, direction, wrap/saturate mode and a wrap carry.

## Interface
- `DIGITS`, default 4: number of BCD digits, 1..8. The count range is 0 .. 10^DIGITS−1.
- `TICK_DIV`, default 50_000_000: prescaler divide ratio, ≥1. Gives a 1 Hz count rate at 50 MHz.
- `SATURATE`, default 0: 0 = wrap at the range ends, 1 = hold at the range ends.
- `clk_50M` in, 1: the single system clock. All logic is on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `en` in, 1: count enable. It is sampled only on tick cycles.
- `up` in, 1: direction. 1 = increment, 0 = decrement.
- `clear` in, 1: synchronous clear to zero.
- `load` in, 1: synchronous load of `load_val`.
- `load_val` in, 4*DIGITS: packed BCD load value. Digit 0 is in bits [3:0].
- `digits` out, 4*DIGITS: packed BCD count value.
- `disp_digits` out, 4*DIGITS: display-ready digits (see Configuration).
- `tick` out, 1: prescaler strobe, one cycle wide.
- `carry` out, 1: one-cycle pulse on wrap (either direction).
- `at_max` out, 1: all digits are 9.
- `at_zero` out, 1: all digits are 0.

## Operation
- The prescaler counts 0..TICK_DIV−1 and returns to 0 after TICK_DIV−1. `tick` is high in the cycle the prescaler equals TICK_DIV−1.
  - With TICK_DIV=1, `tick` is constantly high.
  - The prescaler is free-running. `load`, `clear` and `en` do not affect it; only `rst` zeroes it.
- Per-edge priority is `rst` > `clear` > `load` > step. A step happens when `tick & en`.
- **Step up:** digit 0 increments. A digit at 9 goes to 0 and propagates a carry to the next digit. Propagation is combinational, all in the same cycle.
- **Step down:** digit 0 decrements. A digit at 0 goes to 9 and propagates a borrow to the next digit.
- **Range end, SATURATE=0:** the count wraps, all-9s → 0 going up and 0 → all-9s going down. `carry` pulses on the wrap.
- **Range end, SATURATE=1:** the count holds at the end value and `carry` stays low.
- **Load:** any `load_val` digit greater than 9 is clamped to 9 before it is stored. Load ignores `tick` and `en`.
- **Simultaneous events:** when `clear` or `load` coincide with a step, the step is discarded and `carry` stays low.
- `at_max` and `at_zero` are decoded combinationally from the registered `digits`.

## Timing
- **Reset values:** `digits`=0, prescaler=0, `carry`=0, `tick`=0.
  - `at_zero`=1 and `at_max`=0.
  - `disp_digits` holds the blank pattern of zero: all 0 without the macro, and all 4'hF except digit 0 with the macro.
- `digits` updates on the edge that samples `tick & en`, `load` or `clear`, and is visible the next cycle. Latency is 1 cycle.
- `carry` is registered with `digits`. It is high for exactly the one cycle in which the wrapped value is first visible.
- `tick` is registered and is high one cycle in every TICK_DIV cycles. The first `tick` is in cycle TICK_DIV−1 after `rst` deasserts.
- An `rst` assertion mid-count takes effect on the next edge. There is no partial state.
- `disp_digits` is combinational from `digits`. It adds no extra latency.

## Configuration
- `BCD_COUNTER_LEAD_BLANK_EN` defined: leading-zero blanking is compiled in.
  - Every digit above the most significant non-zero digit drives 4'hF on `disp_digits`. 4'hF is the blank code of the TM1638 driver.
  - Digit 0 is never blanked.
- Macro undefined: `disp_digits` equals `digits` and the blanking logic is absent.
- `digits` is unaffected in both cases.

## Structure
- Package `bcd_counter_pkg` holds:
  - `BCD_W` = 4
  - `BLANK_CODE` = 4'hF
  - `BCD_MAX` = 4'd9
  - function `bcd_clamp(d)`
- Sub-module `bcd_digit_cell` is one digit register step. Inputs are `up` and carry/borrow in; outputs are next digit and carry/borrow out. The top instantiates it DIGITS times in a generate loop.
- The prescaler, priority mux, flags and blanking live in the top module.

## Test plan
- **Reset and tick:** DIGITS=4, TICK_DIV=4, SATURATE=0. Hold `rst` for 3 cycles, then release → `digits`=0000, `at_zero`=1, `tick` is high in cycles 3, 7 and 11 after release.
- **Up wrap:** `load_val`=16'h9998, `en`=1, `up`=1 → after 2 ticks `digits`=0000 and `carry` is high for exactly 1 cycle. After the next tick `digits`=0001.
- **Down with borrow:** `load_val`=16'h1000, `up`=0 → after 1 tick `digits`=0999; starting from 0000 → 9999 with a `carry` pulse.
- **Saturate:** SATURATE=1, `load_val`=16'h9999, `up`=1, 3 ticks → `digits` holds at 9999, `carry` stays 0, `at_max`=1.
- **Priority and clamp:** `clear`, `load` (16'h12AF) and a tick all asserted on the same edge → `digits`=0000. `load` alone with 16'h12AF → `digits`=1299. `rst` asserted mid-count → 0000 on the next edge.
- **Blanking:** with the macro defined, `digits`=0042 → `disp_digits`=16'hFF42, and 0000 → FFF0. With the macro undefined → 0042.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared constants and helpers for the BCD up/down counter.
package bcd_counter_pkg;

    localparam int         BCD_W      = 4;
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [3:0] BCD_MAX    = 4'd9;

    // Force a nibble into the legal BCD range; codes A..F become 9.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the counter chain: computes the digit's next value and
// the carry (counting up) or borrow (counting down) into the next digit.
import bcd_counter_pkg::*;

module bcd_digit_cell (
    input  logic [3:0] digit_i,
    input  logic       up_i,
    input  logic       cin_i,
    output logic [3:0] digit_o,
    output logic       cout_o
);

    // A digit moves only when the digits below it roll over (cin_i).
    always_comb begin
        digit_o = digit_i;
        cout_o  = 1'b0;
        if (cin_i) begin
            if (up_i) begin
                if (digit_i >= BCD_MAX) begin
                    digit_o = 4'd0;
                    cout_o  = 1'b1;
                end else begin
                    digit_o = digit_i + 4'd1;
                end
            end else begin
                if (digit_i == 4'd0) begin
                    digit_o = BCD_MAX;
                    cout_o  = 1'b1;
                end else begin
                    digit_o = digit_i - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit packed-BCD up/down counter with a free-running tick prescaler,
// clear/load, wrap or saturate at the range ends and a wrap carry pulse.
// Optional leading-zero blanking on disp_digits: BCD_COUNTER_LEAD_BLANK_EN.
import bcd_counter_pkg::*;

module bcd_updown_counter #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter bit SATURATE = 1'b0
) (
    input  logic                    clk_50M,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up,
    input  logic                    clear,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    output logic [BCD_W*DIGITS-1:0] digits,
    output logic [BCD_W*DIGITS-1:0] disp_digits,
    output logic                    tick,
    output logic                    carry,
    output logic                    at_max,
    output logic                    at_zero
);

    localparam int W  = BCD_W * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic [W-1:0]  digits_q, digits_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  step_val;
    logic [DIGITS:0] chain;
    logic          wrap;

    // Prescaler next value; tick is registered so it lines up with the
    // cycle in which the prescaler sits at its last value.
    always_comb begin
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        tick_d  = (presc_d == PRESC_LAST);
    end

    // Free-running prescaler; only rst touches it.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    // Ripple of carry/borrow through all digits in a single cycle.
    assign chain[0] = 1'b1;
    for (genvar i = 0; i < DIGITS; i++) begin : gen_cell
        bcd_digit_cell u_cell (
            .digit_i (digits_q[BCD_W*i +: BCD_W]),
            .up_i    (up),
            .cin_i   (chain[i]),
            .digit_o (step_val[BCD_W*i +: BCD_W]),
            .cout_o  (chain[i+1])
        );
    end
    assign wrap = chain[DIGITS];

    // Priority clear > load > step; a step that would wrap is dropped when
    // saturating, and a step discarded by clear/load never raises carry.
    always_comb begin
        digits_d = digits_q;
        carry_d  = 1'b0;
        if (clear) begin
            digits_d = '0;
        end else if (load) begin
            for (int i = 0; i < DIGITS; i++) begin
                digits_d[BCD_W*i +: BCD_W] = bcd_clamp(load_val[BCD_W*i +: BCD_W]);
            end
        end else if (tick_q && en) begin
            if (!(wrap && SATURATE)) begin
                digits_d = step_val;
                carry_d  = wrap;
            end
        end
    end

    // Count and carry registers.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            digits_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            digits_q <= digits_d;
            carry_q  <= carry_d;
        end
    end

    assign digits  = digits_q;
    assign tick    = tick_q;
    assign carry   = carry_q;
    assign at_zero = (digits_q == '0);
    assign at_max  = (digits_q == {DIGITS{BCD_MAX}});

`ifdef BCD_COUNTER_LEAD_BLANK_EN
    logic seen_nz;

    // Blank every digit above the most significant non-zero one; digit 0
    // always shows so a zero count still displays "0".
    always_comb begin
        disp_digits = digits_q;
        seen_nz     = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (digits_q[BCD_W*i +: BCD_W] != 4'd0) begin
                seen_nz = 1'b1;
            end
            if (!seen_nz) begin
                disp_digits[BCD_W*i +: BCD_W] = BLANK_CODE;
            end
        end
    end
`else
    assign disp_digits = digits_q;
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter (DIGITS=4, TICK_DIV=4), with a
// wrapping and a saturating instance driven by the same stimulus.
module tb_bcd_updown_counter;

    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 4;
    localparam int W        = 4 * DIGITS;
    localparam int MAXV     = 9999;

    logic clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;

    logic         rst, en, up, clear, load;
    logic [W-1:0] load_val;
    logic [W-1:0] digits, disp_digits, s_digits, s_disp_digits;
    logic         tick, carry, at_max, at_zero;
    logic         s_tick, s_carry, s_at_max, s_at_zero;

    bcd_updown_counter #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SATURATE(1'b0)) dut (
        .clk_50M(clk_50M), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .digits(digits), .disp_digits(disp_digits), .tick(tick),
        .carry(carry), .at_max(at_max), .at_zero(at_zero)
    );

    bcd_updown_counter #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SATURATE(1'b1)) dut_sat (
        .clk_50M(clk_50M), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .digits(s_digits), .disp_digits(s_disp_digits), .tick(s_tick),
        .carry(s_carry), .at_max(s_at_max), .at_zero(s_at_zero)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected results pushed when stimulus is applied.
    logic [W-1:0] exp_q[$];
    logic         exp_c_q[$];
    logic [W-1:0] exp_sq[$];
    logic         exp_sc_q[$];

    // Reference model state (integers, not BCD).
    int m_val   = 0;
    int m_sval  = 0;
    int m_presc = 0;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [W-1:0] lv);
        int v, p, n;
        v = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            n = int'(lv[4*i +: 4]);
            if (n > 9) n = 9;
            v = v + n * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] exp_disp(input int v);
        logic [W-1:0] r;
        int p;
        r = to_bcd(v);
        p = 1;
`ifdef BCD_COUNTER_LEAD_BLANK_EN
        for (int i = 1; i < DIGITS; i++) begin
            p = p * 10;
            if (v < p) r[4*i +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    // Apply the current inputs for one edge: model the result, push it,
    // then advance to just after the edge.
    task automatic clk_step();
        logic m_tick;
        logic c;
        int nv, ns;
        m_tick = (m_presc == TICK_DIV - 1);
        nv = m_val;
        ns = m_sval;
        c  = 1'b0;
        if (rst) begin
            nv = 0;
            ns = 0;
            m_presc = 0;
        end else begin
            m_presc = (m_presc + 1) % TICK_DIV;
            if (clear) begin
                nv = 0;
                ns = 0;
            end else if (load) begin
                nv = clamp_val(load_val);
                ns = nv;
            end else if (m_tick && en) begin
                if (up) begin
                    if (m_val == MAXV) begin nv = 0; c = 1'b1; end
                    else nv = m_val + 1;
                    ns = (m_sval == MAXV) ? MAXV : m_sval + 1;
                end else begin
                    if (m_val == 0) begin nv = MAXV; c = 1'b1; end
                    else nv = m_val - 1;
                    ns = (m_sval == 0) ? 0 : m_sval - 1;
                end
            end
        end
        m_val  = nv;
        m_sval = ns;
        exp_q.push_back(to_bcd(nv));
        exp_c_q.push_back(c);
        exp_sq.push_back(to_bcd(ns));
        exp_sc_q.push_back(1'b0);
        @(posedge clk_50M);
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] e, es;
        logic ec, esc;
        rst = 1'b1; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
        repeat (3) begin
            clk_step();
            e = exp_q.pop_front(); ec = exp_c_q.pop_front();
            es = exp_sq.pop_front(); esc = exp_sc_q.pop_front();
            checks++; if (digits !== e) begin errors++; $display("FAIL reset.digits: got %h expected %h", digits, e); end
            checks++; if (s_digits !== es) begin errors++; $display("FAIL reset.s_digits: got %h expected %h", s_digits, es); end
        end
        checks++; if (at_zero !== 1'b1) begin errors++; $display("FAIL reset.at_zero: got %b expected 1", at_zero); end
        checks++; if (at_max !== 1'b0) begin errors++; $display("FAIL reset.at_max: got %b expected 0", at_max); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset.tick: got %b expected 0", tick); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset.carry: got %b expected 0", carry); end
        checks++; if (disp_digits !== exp_disp(0)) begin errors++; $display("FAIL reset.disp: got %h expected %h", disp_digits, exp_disp(0)); end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (tick !== ((k % 4) == 3)) begin
                errors++; $display("FAIL reset.tick_cycle%0d: got %b expected %b", k, tick, ((k % 4) == 3));
            end
            clk_step();
            e = exp_q.pop_front(); ec = exp_c_q.pop_front();
            es = exp_sq.pop_front(); esc = exp_sc_q.pop_front();
            checks++; if (digits !== e) begin errors++; $display("FAIL reset.idle_digits: got %h expected %h", digits, e); end
        end
    endtask

    task automatic test_up_wrap();
        logic [W-1:0] e, es, wrap_val;
        logic ec, esc;
        int ncarry;
        ncarry = 0; wrap_val = '1;
        en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h9998;
        for (int k = 0; k < 13; k++) begin
            clk_step();
            load = 1'b0;
            e = exp_q.pop_front(); ec = exp_c_q.pop_front();
            es = exp_sq.pop_front(); esc = exp_sc_q.pop_front();
            checks++; if (digits !== e) begin errors++; $display("FAIL up_wrap.digits: got %h expected %h", digits, e); end
            checks++; if (carry !== ec) begin errors++; $display("FAIL up_wrap.carry: got %b expected %b", carry, ec); end
            if (carry === 1'b1) begin ncarry++; wrap_val = digits; end
        end
        checks++; if (ncarry != 1) begin errors++; $display("FAIL up_wrap.carry_count: got %0d expected 1", ncarry); end
        checks++; if (wrap_val !== 16'h0000) begin errors++; $display("FAIL up_wrap.wrap_value: got %h expected 0000", wrap_val); end
        checks++; if (digits !== 16'h0001) begin errors++; $display("FAIL up_wrap.final: got %h expected 0001", digits); end
    endtask

    task automatic test_down_borrow();
        logic [W-1:0] e, es;
        logic ec, esc;
        int ncarry;
        ncarry = 0;
        en = 1'b1; up = 1'b0; load = 1'b1; load_val = 16'h1000;
        for (int k = 0; k < 5; k++) begin
            clk_step();
            load = 1'b0;
            e = exp_q.pop_front(); ec = exp_c_q.pop_front();
            es = exp_sq.pop_front(); esc = exp_sc_q.pop_front();
            checks++; if (digits !== e) begin errors++; $display("FAIL down.digits: got %h expected %h", digits, e); end
        end
        checks++; if (digits !== 16'h0999) begin errors++; $display("FAIL down.borrow_chain: got %h expected 0999", digits); end
        clear = 1'b1;
        for (int k = 0; k < 5; k++) begin
            clk_step();
            clear = 1'b0;
            e = exp_q.pop_front(); ec = exp_c_q.pop_front();
            es = exp_sq.pop_front(); esc = exp_sc_q.pop_front();
            checks++; if (digits !== e) begin errors++; $display("FAIL down.wrap_digits: got %h expected %h", digits, e); end
            checks++; if (carry !== ec) begin errors++; $display("FAIL down.wrap_carry: got %b expected %b", carry, ec); end
            if (carry === 1'b1) ncarry++;
        end
        checks++; if (digits !== 16'h9999) begin errors++; $display("FAIL down.wrap_final: got %h expected 9999", digits); end
        checks++; if (ncarry != 1) begin errors++; $display("FAIL down.carry_count: got %0d expected 1", ncarry); end
    endtask

    task automatic test_saturate();
        logic [W-1:0] e, es;
        logic ec, esc;
        int ncarry;
        ncarry = 0;
        en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h9999;
        for (int k = 0; k < 13; k++) begin
            clk_step();
            load = 1'b0;
            e = exp_q.pop_front(); ec = exp_c_q.pop_front();
            es = exp_sq.pop_front(); esc = exp_sc_q.pop_front();
            checks++; if (s_digits !== es) begin errors++; $display("FAIL sat.digits: got %h expected %h", s_digits, es); end
            checks++; if (s_carry !== esc) begin errors++; $display("FAIL sat.carry: got %b expected %b", s_carry, esc); end
            checks++; if (digits !== e) begin errors++; $display("FAIL sat.wrap_instance: got %h expected %h", digits, e); end
            if (s_carry === 1'b1) ncarry++;
        end
        checks++; if (s_digits !== 16'h9999) begin errors++; $display("FAIL sat.hold: got %h expected 9999", s_digits); end
        checks++; if (ncarry != 0) begin errors++; $display("FAIL sat.carry_count: got %0d expected 0", ncarry); end
        checks++; if (s_at_max !== 1'b1) begin errors++; $display("FAIL sat.at_max: got %b expected 1", s_at_max); end
    endtask

    task automatic test_priority();
        logic [W-1:0] e, es;
        logic ec, esc;
        int budget;
        en = 1'b0; up = 1'b1;
        budget = 0;
        while (tick !== 1'b1 && budget < 8) begin
            clk_step();
            budget++;
            e = exp_q.pop_front(); ec = exp_c_q.pop_front();
            es = exp_sq.pop_front(); esc = exp_sc_q.pop_front();
            checks++; if (digits !== e) begin errors++; $display("FAIL prio.wait_digits: got %h expected %h", digits, e); end
        end
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL prio.tick_timeout: got %b expected 1", tick); end
        en = 1'b1; clear = 1'b1; load = 1'b1; load_val = 16'h12AF;
        clk_step();
        clear = 1'b0; load = 1'b0; en = 1'b0;
        e = exp_q.pop_front(); ec = exp_c_q.pop_front();
        es = exp_sq.pop_front(); esc = exp_sc_q.pop_front();
        checks++; if (digits !== e) begin errors++; $display("FAIL prio.clear_model: got %h expected %h", digits, e); end
        checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL prio.clear_wins: got %h expected 0000", digits); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL prio.carry: got %b expected 0", carry); end
        load = 1'b1;
        clk_step();
        load = 1'b0;
        e = exp_q.pop_front(); ec = exp_c_q.pop_front();
        es = exp_sq.pop_front(); esc = exp_sc_q.pop_front();
        checks++; if (digits !== 16'h1299) begin errors++; $display("FAIL prio.load_clamp: got %h expected 1299", digits); end
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            clk_step();
            e = exp_q.pop_front(); ec = exp_c_q.pop_front();
            es = exp_sq.pop_front(); esc = exp_sc_q.pop_front();
            checks++; if (digits !== e) begin errors++; $display("FAIL prio.count: got %h expected %h", digits, e); end
        end
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        e = exp_q.pop_front(); ec = exp_c_q.pop_front();
        es = exp_sq.pop_front(); esc = exp_sc_q.pop_front();
        checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL prio.mid_reset: got %h expected 0000", digits); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL prio.reset_tick: got %b expected 0", tick); end
        checks++; if (at_zero !== 1'b1) begin errors++; $display("FAIL prio.reset_at_zero: got %b expected 1", at_zero); end
    endtask

    task automatic test_blanking();
        logic [W-1:0] e, es, want;
        logic ec, esc;
        logic [W-1:0] vals[3];
        logic [W-1:0] blanked[3];
        vals[0] = 16'h0042; blanked[0] = 16'hFF42;
        vals[1] = 16'h0000; blanked[1] = 16'hFFF0;
        vals[2] = 16'h0100; blanked[2] = 16'hF100;
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            load = 1'b1; load_val = vals[k];
            clk_step();
            load = 1'b0;
            e = exp_q.pop_front(); ec = exp_c_q.pop_front();
            es = exp_sq.pop_front(); esc = exp_sc_q.pop_front();
`ifdef BCD_COUNTER_LEAD_BLANK_EN
            want = blanked[k];
`else
            want = vals[k];
`endif
            checks++; if (digits !== vals[k]) begin errors++; $display("FAIL blank.digits: got %h expected %h", digits, vals[k]); end
            checks++; if (disp_digits !== want) begin errors++; $display("FAIL blank.disp: got %h expected %h", disp_digits, want); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e, es;
        logic ec, esc;
        for (int k = 0; k < 120; k++) begin
            rst      = ($urandom_range(0, 39) == 0);
            clear    = ($urandom_range(0, 9) == 0);
            load     = ($urandom_range(0, 5) == 0);
            load_val = W'($urandom_range(0, 65535));
            en       = ($urandom_range(0, 3) != 0);
            up       = $urandom_range(0, 1) == 1;
            clk_step();
            e = exp_q.pop_front(); ec = exp_c_q.pop_front();
            es = exp_sq.pop_front(); esc = exp_sc_q.pop_front();
            checks++; if (digits !== e) begin errors++; $display("FAIL rand.digits: got %h expected %h", digits, e); end
            checks++; if (carry !== ec) begin errors++; $display("FAIL rand.carry: got %b expected %b", carry, ec); end
            checks++; if (s_digits !== es) begin errors++; $display("FAIL rand.s_digits: got %h expected %h", s_digits, es); end
            checks++; if (s_carry !== esc) begin errors++; $display("FAIL rand.s_carry: got %b expected %b", s_carry, esc); end
            checks++; if (at_zero !== (m_val == 0)) begin errors++; $display("FAIL rand.at_zero: got %b expected %b", at_zero, (m_val == 0)); end
            checks++; if (at_max !== (m_val == MAXV)) begin errors++; $display("FAIL rand.at_max: got %b expected %b", at_max, (m_val == MAXV)); end
            checks++; if (tick !== (m_presc == TICK_DIV - 1)) begin errors++; $display("FAIL rand.tick: got %b expected %b", tick, (m_presc == TICK_DIV - 1)); end
            checks++; if (disp_digits !== exp_disp(m_val)) begin errors++; $display("FAIL rand.disp: got %h expected %h", disp_digits, exp_disp(m_val)); end
        end
        rst = 1'b0; clear = 1'b0; load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
        test_reset();
        test_up_wrap();
        test_down_borrow();
        test_saturate();
        test_priority();
        test_blanking();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
